wide_add_seq: RTL and testbench

- Multi-precision add/subtract sequencer that time-shares one 16-bit prefix adder (a, b, cin → sum, cout) over LIMBS cycles.
- Takes LIMBS*16-bit operands over a valid/ready handshake.
- Drives one 16-bit limb per cycle into the adder and chains the carry through a register.
- Returns the full-width result, carry-out and signed overflow over a second valid/ready handshake.
- The adder is instantiated beside this block; the sequencer only connects to its ports.

---
 rtl/wide_add_seq_pkg.sv | 21 ++
 rtl/wide_add_seq_limb_mux.sv | 17 +
 rtl/wide_add_seq.sv | 139 +++++++++++++
 tb/tb_wide_add_seq.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/wide_add_seq_pkg.sv
// rtl/wide_add_seq_pkg.sv - shared constants, state encoding and limb select for wide_add_seq
package wide_add_seq_pkg;

  localparam int LIMB_W    = 16;
  localparam int MAX_LIMBS = 16;
  localparam int MAX_W     = LIMB_W * MAX_LIMBS;
  localparam int IDX_W     = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // Callers zero-extend their operand to MAX_W so one function serves every LIMBS.
  function automatic logic [LIMB_W-1:0] limb_sel(input logic [MAX_W-1:0] vec,
                                                 input logic [IDX_W-1:0] idx);
    return vec[idx*LIMB_W +: LIMB_W];
  endfunction

endpackage

// File: rtl/wide_add_seq_limb_mux.sv
// rtl/wide_add_seq_limb_mux.sv - picks the idx'th 16-bit limb of both operand registers
module limb_mux
  import wide_add_seq_pkg::*;
#(
  parameter int LIMBS = 4
) (
  input  logic [LIMBS*LIMB_W-1:0] a_vec,
  input  logic [LIMBS*LIMB_W-1:0] b_vec,
  input  logic [IDX_W-1:0]        idx,
  output logic [LIMB_W-1:0]       a_limb,
  output logic [LIMB_W-1:0]       b_limb
);

  assign a_limb = limb_sel(MAX_W'(a_vec), idx);
  assign b_limb = limb_sel(MAX_W'(b_vec), idx);

endmodule

// File: rtl/wide_add_seq.sv
// rtl/wide_add_seq.sv - multi-limb add/sub sequencer driving one external 16-bit adder
// Optional zero-result flag enabled by WIDE_ADD_SEQ_ZERO_FLAG_EN.
module wide_add_seq
  import wide_add_seq_pkg::*;
#(
  parameter int LIMBS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LIMBS*LIMB_W-1:0] a,
  input  logic [LIMBS*LIMB_W-1:0] b,
  input  logic                    cin,
  input  logic                    op_sub,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LIMBS*LIMB_W-1:0] sum,
  output logic                    cout,
  output logic                    ovf,
  output logic [LIMB_W-1:0]       add_a,
  output logic [LIMB_W-1:0]       add_b,
  output logic                    add_cin,
  input  logic [LIMB_W-1:0]       add_sum,
  input  logic                    add_cout
`ifdef WIDE_ADD_SEQ_ZERO_FLAG_EN
  ,
  output logic                    zero
`endif
);

  localparam int W = LIMBS * LIMB_W;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(LIMBS - 1);

  state_t            state, state_nxt;
  logic [W-1:0]      a_reg, b_reg, sum_reg;
  logic              carry_reg, cout_reg, ovf_reg;
  logic [IDX_W-1:0]  idx;
  logic [LIMB_W-1:0] mux_a, mux_b;

  limb_mux #(.LIMBS(LIMBS)) u_limb_mux (
    .a_vec  (a_reg),
    .b_vec  (b_reg),
    .idx    (idx),
    .a_limb (mux_a),
    .b_limb (mux_b)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    add_a     = '0;
    add_b     = '0;
    add_cin   = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        add_a   = mux_a;
        add_b   = mux_b;
        add_cin = carry_reg;
        if (idx == LAST) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Subtraction is folded into the operands: b is stored inverted and the borrow-in flipped.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      cout_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
      idx       <= '0;
    end else begin
      case (state)
        IDLE: begin
          idx <= '0;
          if (in_valid) begin
            a_reg     <= a;
            b_reg     <= op_sub ? ~b : b;
            carry_reg <= cin ^ op_sub;
          end
        end
        RUN: begin
          for (int i = 0; i < LIMBS; i++) begin
            if (idx == IDX_W'(i)) sum_reg[i*LIMB_W +: LIMB_W] <= add_sum;
          end
          carry_reg <= add_cout;
          if (idx != LAST) begin
            idx <= idx + 1'b1;
          end else begin
            cout_reg <= add_cout;
            ovf_reg  <= (a_reg[W-1] == b_reg[W-1]) && (add_sum[LIMB_W-1] != a_reg[W-1]);
          end
        end
        default: ;
      endcase
    end
  end

  assign sum  = sum_reg;
  assign cout = cout_reg;
  assign ovf  = ovf_reg;

`ifdef WIDE_ADD_SEQ_ZERO_FLAG_EN
  logic nz_acc, zero_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      nz_acc   <= 1'b0;
      zero_reg <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      nz_acc <= 1'b0;
    end else if (state == RUN) begin
      nz_acc <= nz_acc | (|add_sum);
      if (idx == LAST) zero_reg <= ~(nz_acc | (|add_sum));
    end
  end

  assign zero = zero_reg;
`endif

endmodule

// File: tb/tb_wide_add_seq.sv
// tb/tb_wide_add_seq.sv - scoreboard bench for wide_add_seq with a behavioural 16-bit adder
module tb_wide_add_seq;

  localparam int LIMBS = 4;
  localparam int W     = LIMBS * 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, cin, op_sub;
  logic [W-1:0]  a, b, sum;
  logic          out_valid, out_ready, cout, ovf;
  logic [15:0]   add_a, add_b, add_sum;
  logic          add_cin, add_cout;
`ifdef WIDE_ADD_SEQ_ZERO_FLAG_EN
  logic          zero;
`endif

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {16'b0, add_cin};

  wide_add_seq #(.LIMBS(LIMBS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .op_sub    (op_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_sum   (add_sum),
    .add_cout  (add_cout)
`ifdef WIDE_ADD_SEQ_ZERO_FLAG_EN
    ,
    .zero      (zero)
`endif
  );

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] want);
    n_cmp++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  // Reference: true signed/unsigned arithmetic on the whole operand, no limbs.
  function automatic exp_t model(input logic [W-1:0] va, input logic [W-1:0] vb,
                                 input logic vc, input logic vs);
    exp_t e;
    logic signed [W+1:0] sres;
    logic [W:0] ua, ub;
    ua = {1'b0, va};
    ub = {1'b0, vb};
    if (!vs) begin
      e.sum  = va + vb + W'(vc);
      e.cout = ((ua + ub + (W+1)'(vc)) >> W) != 0;
      sres   = $signed({{2{va[W-1]}}, va}) + $signed({{2{vb[W-1]}}, vb}) + $signed((W+2)'(vc));
    end else begin
      e.sum  = va - vb - W'(vc);
      e.cout = ua >= (ub + (W+1)'(vc));
      sres   = $signed({{2{va[W-1]}}, va}) - $signed({{2{vb[W-1]}}, vb}) - $signed((W+2)'(vc));
    end
    e.ovf  = (sres > $signed({3'b000, {(W-1){1'b1}}})) || (sres < -$signed({3'b001, {(W-1){1'b0}}}));
    e.zero = (e.sum == '0);
    return e;
  endfunction

  task automatic issue(input logic [W-1:0] va, input logic [W-1:0] vb,
                       input logic vc, input logic vs);
    bit got = 0;
    @(posedge clk) #1;
    a = va; b = vb; cin = vc; op_sub = vs; in_valid = 1'b1;
    for (int g = 0; g < 50 && !got; g++) begin
      @(negedge clk);
      if (in_ready) got = 1;
      @(posedge clk);
    end
    chk("accept", W'(got), W'(1));
    exp_q.push_back(model(va, vb, vc, vs));
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int cnt = 0;
    bit seen = 0;
    for (int g = 0; g < 40 && !seen; g++) begin
      @(posedge clk);
      cnt++;
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    chk("latency", W'(cnt), W'(LIMBS));
  endtask

  task automatic release_out(input int k);
    repeat (k) @(posedge clk);
    @(posedge clk) #1 out_ready = 1'b1;
    @(posedge clk) #1 out_ready = 1'b0;
  endtask

  task automatic run_op(input logic [W-1:0] va, input logic [W-1:0] vb,
                        input logic vc, input logic vs, input int k);
    issue(va, vb, vc, vs);
    wait_valid();
    release_out(k);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return {1'b0, {(W-1){1'b1}}};
      3:       return {1'b1, {(W-1){1'b0}}};
      default: return {$urandom(), $urandom()};
    endcase
  endfunction

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_result: got sum %0h expected no result", sum);
        end else begin
          e = exp_q[0];
          chk("sum", sum, e.sum);
          chk("cout", W'(cout), W'(e.cout));
          chk("ovf", W'(ovf), W'(e.ovf));
`ifdef WIDE_ADD_SEQ_ZERO_FLAG_EN
          chk("zero", W'(zero), W'(e.zero));
`endif
          if (out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; op_sub = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst_in_ready", W'(in_ready), W'(1));
    chk("rst_out_valid", W'(out_valid), W'(0));
    chk("rst_sum", sum, '0);
    chk("rst_cout", W'(cout), W'(0));
    chk("rst_ovf", W'(ovf), W'(0));
    chk("rst_add_a", W'(add_a), W'(0));
    chk("rst_add_cin", W'(add_cin), W'(0));

    run_op(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0, 0);
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 0);
    run_op(64'h5, 64'h7, 1'b0, 1'b1, 1);
    run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 0);

    // Backpressure: second request held on in_valid while the first result stalls.
    issue(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 1'b0);
    wait_valid();
    @(posedge clk) #1;
    a = 64'h8000_0000_0000_0000; b = 64'h1; cin = 1'b0; op_sub = 1'b1; in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready", W'(in_ready), W'(0));
    end
    @(posedge clk) #1 out_ready = 1'b1;
    @(posedge clk) #1 out_ready = 1'b0;
    chk("bp_idle_in_ready", W'(in_ready), W'(1));
    chk("bp_idle_out_valid", W'(out_valid), W'(0));
    exp_q.push_back(model(64'h8000_0000_0000_0000, 64'h1, 1'b0, 1'b1));
    @(posedge clk) #1 in_valid = 1'b0;
    wait_valid();
    release_out(0);

    // out_ready with nothing pending must not produce anything.
    @(posedge clk) #1 out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 out_ready = 1'b0;
    chk("idle_ready_out_valid", W'(out_valid), W'(0));

    // Reset while idx==2 with a live carry, then a request that must see no leaked carry.
    issue(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
    exp_q.delete();
    @(posedge clk);
    @(posedge clk) #1 rst = 1'b1;
    @(posedge clk) #1 rst = 1'b0;
    chk("abort_in_ready", W'(in_ready), W'(1));
    chk("abort_out_valid", W'(out_valid), W'(0));
    chk("abort_sum", sum, '0);
    run_op(64'h0, 64'h0, 1'b0, 1'b0, 0);
    run_op(64'hFFFF, 64'h0, 1'b0, 1'b0, 0);

    for (int n = 0; n < 60; n++) begin
      run_op(pick(), pick(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             int'($urandom_range(0, 3)));
    end

    repeat (5) @(posedge clk);
    chk("queue_drained", W'(exp_q.size()), W'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
